// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic gnt_any;
  logic gnt_id;

  // On a tie the requester that was not served last wins.
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    res_d      = res_q;
    zero_d     = zero_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (rst && gnt_any) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          a_d        = gnt_id ? req1_a : req0_a;
          b_d        = gnt_id ? req1_b : req0_b;
          op_d       = gnt_id ? req1_op : req0_op;
          id_d       = gnt_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_q;
        res_d   = alu_result;
        zero_d  = alu_zero;
        err_d   = op_q[2] & op_q[1];
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and
// a transaction-level arbitration/latency model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_result;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  bit   id_log[$];
  int   checks = 0, failures = 0;

  bit           busy = 0, last = 1, cur_id = 0, acc0 = 0, acc1 = 0;
  bit           w0, w1, last_acc_id = 0;
  int           age = 0, acc_cnt = 0, rsp_cnt = 0;
  logic [W-1:0] cur_a, cur_b;
  logic [2:0]   cur_op;
  rsp_t         last_rsp, e, e_new;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: who may be granted, when the ALU is driven, when rsp appears.
  initial forever begin
    @(negedge clk);
    acc0 = 0;
    acc1 = 0;
    if (!rst) begin
      busy = 0;
      last = 1;
      exp_q.delete();
      chk("ready_in_reset", {req0_ready, req1_ready}, 0);
    end else if (busy) begin
      age++;
      chk("ready_busy", {req0_ready, req1_ready}, 0);
      chk("rsp_valid_timing", rsp_valid, age >= 2);
      if (age == 1)
        chk("alu_drive", {alu_op, alu_a, alu_b}, {cur_op, cur_a, cur_b});
      else
        chk("alu_quiet", {alu_op, alu_a, alu_b}, 0);
      if (rsp_valid && rsp_ready && age >= 2) begin
        busy = 0;
        last = cur_id;
      end
    end else begin
      w0 = req0_valid && (!req1_valid || last);
      w1 = req1_valid && (!req0_valid || !last);
      chk("grant", {req0_ready, req1_ready}, {w0, w1});
      chk("alu_quiet_idle", {alu_op, alu_a, alu_b}, 0);
      chk("rsp_valid_idle", rsp_valid, 0);
      if (w0 || w1) begin
        cur_id = w1;
        cur_a  = w1 ? req1_a : req0_a;
        cur_b  = w1 ? req1_b : req0_b;
        cur_op = w1 ? req1_op : req0_op;
        e_new.id   = cur_id;
        e_new.res  = alu_f(cur_op, cur_a, cur_b);
        e_new.zero = (e_new.res == '0);
        e_new.err  = (cur_op >= 3'd6);
        exp_q.push_back(e_new);
        busy = 1;
        age = 0;
        acc_cnt++;
        acc0 = w0;
        acc1 = w1;
        last_acc_id = w1;
      end
    end
  end

  // Monitor: compares every presented response against the queue head.
  initial forever begin
    @(negedge clk);
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%0h required=none", rsp_result);
      end else begin
        e = exp_q[0];
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("rsp_err", rsp_err, e.err);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          rsp_cnt++;
          last_rsp = '{rsp_id, rsp_result, rsp_zero, rsp_err};
          id_log.push_back(rsp_id);
        end
      end
    end
  end

  task automatic wait_acc(input int n);
    int t = 0;
    do begin @(posedge clk); t++; end while (acc_cnt < n && t < 50);
    #1;
    if (acc_cnt < n) chk("timeout_accept", acc_cnt, n);
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    do begin @(posedge clk); t++; end while (rsp_cnt < n && t < 50);
    #1;
    if (rsp_cnt < n) chk("timeout_rsp", rsp_cnt, n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    repeat (2) tick();
    rst = 1;
  endtask

  task automatic one(input bit id, input logic [2:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    int na = acc_cnt + 1, nr = rsp_cnt + 1;
    if (id) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end
    wait_acc(na);
    req0_valid = 0;
    req1_valid = 0;
    wait_rsp(nr);
  endtask

  task automatic rand_ops(output logic [W-1:0] a, output logic [W-1:0] b,
                          output logic [2:0] op);
    a  = ($urandom % 2) ? W'($urandom) : W'($urandom % 8);
    b  = ($urandom % 2) ? W'($urandom) : W'($urandom % 8);
    op = 3'($urandom % 8);
  endtask

  logic [W-1:0] held;
  int           n0;

  initial begin
    tick();
    do_reset();
    rsp_ready = 1;
    chk("reset_state",
        {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, alu_op, alu_a},
        0);

    one(0, 3'b001, 5, 3);
    chk("add_result", last_rsp, {1'b0, W'(8), 1'b0, 1'b0});

    do_reset();
    id_log.delete();
    n0 = rsp_cnt;
    req0_valid = 1; req0_op = 3'b010; req0_a = 7; req0_b = 7;
    req1_valid = 1; req1_op = 3'b011; req1_a = 1; req1_b = 2;
    wait_rsp(n0 + 1);
    chk("tie_first", last_rsp, {1'b0, W'(0), 1'b1, 1'b0});
    wait_rsp(n0 + 4);
    req0_valid = 0;
    req1_valid = 0;
    chk("alternate_ids", {id_log[0], id_log[1], id_log[2], id_log[3]},
        4'b0101);
    repeat (4) tick();

    rsp_ready = 0;
    n0 = acc_cnt;
    req1_valid = 1; req1_op = 3'b100; req1_a = 'hF0F0; req1_b = 'h0FF0;
    wait_acc(n0 + 1);
    held = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      req1_a = $urandom;
      req1_b = $urandom;
      if (i == 1) held = rsp_result;
    end
    chk("stall_valid", rsp_valid, 1);
    chk("stall_hold", rsp_result, held);
    chk("stall_value", rsp_result, W'('hFF00));
    req1_valid = 0;
    rsp_ready = 1;
    wait_rsp(rsp_cnt + 1);

    one(1, 3'b111, 123, 45);
    chk("err_op", last_rsp, {1'b1, W'(0), 1'b1, 1'b1});
    one(0, 3'b101, -2, 4);
    chk("slt_neg", last_rsp.res, 1);
    one(0, 3'b101, 4, -2);
    chk("slt_pos", last_rsp.res, 0);

    n0 = acc_cnt;
    req0_valid = 1; req0_op = 3'b001; req0_a = 1; req0_b = 2;
    wait_acc(n0 + 1);
    req0_valid = 0;
    rst = 0;
    tick();
    rst = 1;
    chk("abort_valid", {rsp_valid, rsp_result}, 0);
    n0 = rsp_cnt;
    repeat (5) tick();
    chk("abort_no_rsp", rsp_cnt, n0);
    req0_valid = 1; req1_valid = 1;
    req0_op = 3'b000; req1_op = 3'b000;
    wait_acc(acc_cnt + 1);
    chk("tie_after_abort", last_acc_id, 0);
    req0_valid = 0;
    req1_valid = 0;
    wait_rsp(n0 + 1);

    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom % 300) != 0;
      rsp_ready = ($urandom % 4) != 0;
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom % 3) != 0;
        rand_ops(req0_a, req0_b, req0_op);
      end else if ($urandom % 10 == 0) req0_valid = 0;
      else if ($urandom % 8 == 0) rand_ops(req0_a, req0_b, req0_op);
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom % 3) != 0;
        rand_ops(req1_a, req1_b, req1_op);
      end else if ($urandom % 10 == 0) req1_valid = 0;
      else if ($urandom % 8 == 0) rand_ops(req1_a, req1_b, req1_op);
    end

    rst = 1;
    rsp_ready = 1;
    req0_valid = 0;
    req1_valid = 0;
    repeat (10) tick();
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
